// File: rtl/vga_timing_if.sv
// vga_timing_if: enable input and timing outputs between vga_timing_ctrl and the pixel logic
interface vga_timing_if;
  logic       ena;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;
  modport master (input ena, output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt);
  modport slave  (output ena, input hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt);
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA h/v counters, syncs, display enable and line/frame pulses, all registered.
// Optional 8-bit frame counter built only when VGA_FRAME_COUNTER_EN is defined.
module vga_timing_ctrl #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_ctrl: H_TOTAL or V_TOTAL does not fit in 10 bits");
  end
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] HS0      = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1      = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA       = 11'(V_ACTIVE);
  localparam logic [10:0] VS0      = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1      = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_OFF = !SYNC_ACTIVE_HIGH;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic       h_wrap, v_wrap;
  // Level outputs are derived from the next counter values so they line up with hpos/vpos.
  always_comb begin
    h_wrap  = hpos_q == H_LAST;
    v_wrap  = vpos_q == V_LAST;
    hpos_d  = !vga.ena ? hpos_q : h_wrap ? '0 : hpos_q + 10'd1;
    vpos_d  = !(vga.ena && h_wrap) ? vpos_q : v_wrap ? '0 : vpos_q + 10'd1;
    hsync_d = SYNC_OFF ^ ({1'b0, hpos_d} >= HS0 && {1'b0, hpos_d} < HS1);
    vsync_d = SYNC_OFF ^ ({1'b0, vpos_d} >= VS0 && {1'b0, vpos_d} < VS1);
    de_d    = {1'b0, hpos_d} < HA && {1'b0, vpos_d} < VA;
    ls_d    = vga.ena && h_wrap;
    fs_d    = ls_d && v_wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      de_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else if (fs_d) frame_cnt_q <= frame_cnt_q + 8'd1;
  end
  assign vga.frame_cnt = frame_cnt_q;
`else
  assign vga.frame_cnt = 8'h00;
`endif
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for a default-timing DUT and a tiny active-high-sync DUT.
module tb_vga_timing_ctrl;
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  vga_timing_if if0();
  vga_timing_if if1();
  vga_timing_ctrl dut0 (.clk(clk), .rst(rst), .vga(if0.master));
  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_ACTIVE_HIGH(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .vga(if1.master));
  always #5 clk = ~clk;
  // Expected outputs after n enabled cycles since reset; adv marks that this edge advanced.
  function automatic exp_t model(int cnt, bit adv, int ha, int hf, int hw, int hb,
                                 int va, int vf, int vw, int vb, bit pol);
    exp_t e;
    int ht = ha + hf + hw + hb;
    int vt = va + vf + vw + vb;
    int h = cnt % ht;
    int line = cnt / ht;
    int v = line % vt;
    int fr = line / vt;
    bit hact = h >= ha + hf && h < ha + hf + hw;
    bit vact = v >= va + vf && v < va + vf + vw;
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = pol ? hact : !hact;
    e.vs = pol ? vact : !vact;
    e.de = h < ha && v < va;
    e.ls = adv && h == 0;
    e.fs = adv && h == 0 && v == 0;
`ifdef VGA_FRAME_COUNTER_EN
    e.fc = 8'(fr);
`else
    e.fc = 8'h00;
`endif
    return e;
  endfunction
  task automatic step(input bit r, input bit e);
    bit adv = !r && e;
    rst = r;
    if0.ena = e;
    if1.ena = e;
    n = r ? 0 : n + int'(e);
    q0.push_back(model(n, adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    q1.push_back(model(n, adv, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1));
    @(posedge clk);
    #1;
  endtask
  task automatic cmp(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d expected h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
               name, $time, act.h, act.v, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
               req.h, req.v, req.hs, req.vs, req.de, req.ls, req.fs, req.fc);
    end
  endtask
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        cmp("dut0", {if0.hpos, if0.vpos, if0.hsync, if0.vsync, if0.display_on,
                     if0.line_start, if0.frame_start, if0.frame_cnt}, q0.pop_front());
        cmp("dut1", {if1.hpos, if1.vpos, if1.hsync, if1.vsync, if1.display_on,
                     if1.line_start, if1.frame_start, if1.frame_cnt}, q1.pop_front());
      end
    end
  end
  initial begin : stimulus
    if0.ena = 1'b0;
    if1.ena = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 799; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 257 * 84 + 100; i++) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q0.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
